// File: rtl/inert_pkg.sv
// Shared types and SPI command tables for the IMU sequencer.
// Both tables are packed so that element [0] is the first command issued.
package inert_pkg;

    typedef enum logic [2:0] {
        S_PWR,
        S_INIT,
        S_INIT_W,
        S_IDLE,
        S_RD,
        S_RD_W,
        S_VLD
    } state_e;

    localparam int TBL_N = 4;

    // Config writes: INT on data-ready, accel 208Hz, gyro 208Hz, rounding on.
    localparam logic [TBL_N-1:0][15:0] INIT_TBL = {
        16'h1460, 16'h1150, 16'h1053, 16'h0D02
    };

    // Burst reads: pitch low, pitch high, accel Z low, accel Z high.
    localparam logic [TBL_N-1:0][15:0] RD_TBL = {
        16'hAD00, 16'hAC00, 16'hA300, 16'hA200
    };

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
// Both stages reset low.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic ff1_q;
    logic ff2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;

endmodule

// File: rtl/inert_seq.sv
// IMU sequencer: power-up wait, config writes, then a four-byte read burst per data-ready edge.
// ptch_rt/AZ and vld are loaded together on the final done, so the outputs never show a partial sample.
module inert_seq
    import inert_pkg::*;
#(
    parameter int PWR_W  = 16,
    parameter int INIT_N = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ
);

    localparam logic [1:0] IDX_LAST = 2'(INIT_N - 1);

    state_e            state_q, state_d;
    logic [PWR_W-1:0]  pwr_cnt_q, pwr_cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        ridx_q, ridx_d;
    logic [2:0][7:0]   hold_q, hold_d;
    logic              wrt_q, wrt_d;
    logic              vld_q, vld_d;
    logic [15:0]       cmd_q, cmd_d;
    logic [15:0]       ptch_q, ptch_d;
    logic [15:0]       az_q, az_d;

    logic              int_s;
    logic              int_d1_q;
    logic              int_rise;
    logic [7:0]        rd_byte;
    logic              unused_rd_hi;

    sync2 u_int_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (INT),
        .q_o   (int_s)
    );

    assign int_rise     = int_s & ~int_d1_q;
    assign rd_byte      = rd_data[7:0];
    assign unused_rd_hi = ^rd_data[15:8];

    // NOTE: every flop, including the byte holding registers, is cleared by reset
    // so an aborted burst can never leak stale bytes into a later sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_PWR;
            pwr_cnt_q <= '0;
            idx_q     <= '0;
            ridx_q    <= '0;
            hold_q    <= '0;
            wrt_q     <= 1'b0;
            vld_q     <= 1'b0;
            cmd_q     <= '0;
            ptch_q    <= '0;
            az_q      <= '0;
            int_d1_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples pre-edge values.
            state_q   <= state_d;
            pwr_cnt_q <= pwr_cnt_d;
            idx_q     <= idx_d;
            ridx_q    <= ridx_d;
            hold_q    <= hold_d;
            wrt_q     <= wrt_d;
            vld_q     <= vld_d;
            cmd_q     <= cmd_d;
            ptch_q    <= ptch_d;
            az_q      <= az_d;
            int_d1_q  <= int_s;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a latch behind.
        state_d   = state_q;
        pwr_cnt_d = pwr_cnt_q;
        idx_d     = idx_q;
        ridx_d    = ridx_q;
        hold_d    = hold_q;
        wrt_d     = 1'b0;
        vld_d     = 1'b0;
        cmd_d     = cmd_q;
        ptch_d    = ptch_q;
        az_d      = az_q;

        unique case (state_q)
            S_PWR: begin
                if (&pwr_cnt_q) begin
                    state_d = S_INIT;
                    idx_d   = '0;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
                end
            end
            S_INIT: begin
                wrt_d   = 1'b1;
                cmd_d   = INIT_TBL[idx_q];
                state_d = S_INIT_W;
            end
            S_INIT_W: begin
                if (done) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_INIT;
                    end
                end
            end
            S_IDLE: begin
                if (int_rise) begin
                    ridx_d  = '0;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                wrt_d   = 1'b1;
                cmd_d   = RD_TBL[ridx_q];
                state_d = S_RD_W;
            end
            S_RD_W: begin
                if (done) begin
                    // The last byte goes straight to the outputs together with vld.
                    unique case (ridx_q)
                        2'd0: hold_d[0] = rd_byte;
                        2'd1: hold_d[1] = rd_byte;
                        2'd2: hold_d[2] = rd_byte;
                        default: begin
                            ptch_d = {hold_q[1], hold_q[0]};
                            az_d   = {rd_byte, hold_q[2]};
                            vld_d  = 1'b1;
                        end
                    endcase
                    if (ridx_q == 2'd3) begin
                        state_d = S_VLD;
                    end else begin
                        ridx_d  = ridx_q + 2'd1;
                        state_d = S_RD;
                    end
                end
            end
            S_VLD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_PWR;
            end
        endcase
    end

    assign wrt     = wrt_q;
    assign cmd     = cmd_q;
    assign vld     = vld_q;
    assign ptch_rt = ptch_q;
    assign AZ      = az_q;

endmodule

// File: tb/tb_inert_seq.sv
// Directed bench for inert_seq: a simple SPI-slave model answers each wrt with a done
// carrying a chosen byte; expected commands and output words are hand-computed constants.
module tb_inert_seq;

    logic        clk;
    logic        rst_n;
    logic        INT;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic        vld;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;

    int tests_run;
    int tests_failed;
    int wrt_cnt;
    int vld_cnt;

    inert_seq #(
        .PWR_W  (4),
        .INIT_N (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (INT),
        .done    (done),
        .rd_data (rd_data),
        .wrt     (wrt),
        .cmd     (cmd),
        .vld     (vld),
        .ptch_rt (ptch_rt),
        .AZ      (AZ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wrt) wrt_cnt <= wrt_cnt + 1;
        if (vld) vld_cnt <= vld_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_wrt(input int budget, output int n, output logic seen);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (wrt) seen = 1'b1;
        end
    endtask

    // Answer one transaction; returns at the negedge just after done was sampled.
    task automatic spi_txn(input string tag, input logic [15:0] exp_cmd, input logic [7:0] b,
                           output int n_wait);
        logic seen;
        wait_wrt(64, n_wait, seen);
        check({tag, " wrt seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        check({tag, " cmd"}, 32'(cmd), 32'(exp_cmd));
        @(negedge clk);
        check({tag, " wrt pulse"}, 32'(wrt), 32'd0);
        @(negedge clk);
        check({tag, " cmd held"}, 32'(cmd), 32'(exp_cmd));
        done    = 1'b1;
        rd_data = {8'hEE, b};
        @(negedge clk);
        done    = 1'b0;
        rd_data = 16'h0000;
    endtask

    task automatic init_seq(input string tag);
        int n;
        spi_txn({tag, " init0"}, 16'h0D02, 8'h00, n);
        check({tag, " pwr wait clks"}, 32'(n), 32'd17);
        spi_txn({tag, " init1"}, 16'h1053, 8'h00, n);
        spi_txn({tag, " init2"}, 16'h1150, 8'h00, n);
        spi_txn({tag, " init3"}, 16'h1460, 8'h00, n);
    endtask

    task automatic burst(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3,
                         input logic [15:0] exp_pr, input logic [15:0] exp_az);
        int n;
        spi_txn({tag, " rd0"}, 16'hA200, b0, n);
        spi_txn({tag, " rd1"}, 16'hA300, b1, n);
        spi_txn({tag, " rd2"}, 16'hAC00, b2, n);
        spi_txn({tag, " rd3"}, 16'hAD00, b3, n);
        check({tag, " vld"}, 32'(vld), 32'd1);
        check({tag, " ptch_rt"}, 32'(ptch_rt), 32'(exp_pr));
        check({tag, " AZ"}, 32'(AZ), 32'(exp_az));
        @(negedge clk);
        check({tag, " vld pulse"}, 32'(vld), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   w0;
        int   v0;
        logic seen;

        tests_run    = 0;
        tests_failed = 0;
        wrt_cnt      = 0;
        vld_cnt      = 0;
        rst_n        = 1'b0;
        INT          = 1'b0;
        done         = 1'b0;
        rd_data      = 16'h0000;

        // 1. Reset state, power-up wait and init writes.
        repeat (3) @(negedge clk);
        check("rst wrt", 32'(wrt), 32'd0);
        check("rst vld", 32'(vld), 32'd0);
        check("rst cmd", 32'(cmd), 32'd0);
        check("rst ptch_rt", 32'(ptch_rt), 32'd0);
        check("rst AZ", 32'(AZ), 32'd0);
        rst_n = 1'b1;
        init_seq("t1");
        w0 = wrt_cnt;
        repeat (10) @(negedge clk);
        check("t1 idle no wrt", 32'(wrt_cnt - w0), 32'd0);

        // 2. First burst, positive values.
        INT = 1'b1;
        burst("t2", 8'h34, 8'h12, 8'h78, 8'h56, 16'h1234, 16'h5678);
        INT = 1'b0;
        repeat (5) @(negedge clk);

        // 3. Negative values; outputs hold afterwards.
        INT = 1'b1;
        burst("t3", 8'hF0, 8'hFF, 8'h00, 8'h80, 16'hFFF0, 16'h8000);
        INT = 1'b0;
        repeat (20) @(negedge clk);
        check("t3 hold ptch_rt", 32'(ptch_rt), 32'h0000FFF0);
        check("t3 hold AZ", 32'(AZ), 32'h00008000);

        // 4. Spurious done in IDLE, extra INT edge mid-burst.
        w0 = wrt_cnt;
        v0 = vld_cnt;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (10) @(negedge clk);
        check("t4 spurious done wrt", 32'(wrt_cnt - w0), 32'd0);
        INT = 1'b1;
        spi_txn("t4 rd0", 16'hA200, 8'h11, n);
        INT = 1'b0;
        spi_txn("t4 rd1", 16'hA300, 8'h22, n);
        INT = 1'b1;
        check("t4 partial ptch_rt", 32'(ptch_rt), 32'h0000FFF0);
        spi_txn("t4 rd2", 16'hAC00, 8'h33, n);
        spi_txn("t4 rd3", 16'hAD00, 8'h44, n);
        check("t4 ptch_rt", 32'(ptch_rt), 32'h00002211);
        check("t4 AZ", 32'(AZ), 32'h00004433);
        repeat (20) @(negedge clk);
        check("t4 wrt count", 32'(wrt_cnt - w0), 32'd4);
        check("t4 vld count", 32'(vld_cnt - v0), 32'd1);
        INT = 1'b0;
        repeat (5) @(negedge clk);

        // 6. INT held high: one burst per rising edge.
        INT = 1'b1;
        burst("t6a", 8'h01, 8'h02, 8'h03, 8'h04, 16'h0201, 16'h0403);
        w0 = wrt_cnt;
        repeat (30) @(negedge clk);
        check("t6 held INT no wrt", 32'(wrt_cnt - w0), 32'd0);
        INT = 1'b0;
        repeat (5) @(negedge clk);
        INT = 1'b1;
        burst("t6b", 8'hA0, 8'hB1, 8'hC2, 8'hD3, 16'hB1A0, 16'hD3C2);
        INT = 1'b0;
        repeat (5) @(negedge clk);

        // 5. Reset during RD_W of byte 2, then full restart.
        INT = 1'b1;
        spi_txn("t5 rd0", 16'hA200, 8'h55, n);
        spi_txn("t5 rd1", 16'hA300, 8'h66, n);
        wait_wrt(64, n, seen);
        check("t5 rd2 wrt seen", 32'(seen), 32'd1);
        check("t5 rd2 cmd", 32'(cmd), 32'h0000AC00);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        INT   = 1'b0;
        @(negedge clk);
        check("t5 rst ptch_rt", 32'(ptch_rt), 32'd0);
        check("t5 rst AZ", 32'(AZ), 32'd0);
        check("t5 rst vld", 32'(vld), 32'd0);
        check("t5 rst cmd", 32'(cmd), 32'd0);
        v0 = vld_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        init_seq("t5");
        repeat (10) @(negedge clk);
        check("t5 no vld after abort", 32'(vld_cnt - v0), 32'd0);
        check("t5 ptch_rt still 0", 32'(ptch_rt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
